// File: rtl/spi_shift_register_if.sv
// rtl/spi_shift_register_if.sv - control/serial bundle between the SPI control logic and the shift register
//
// Purpose: carries the frame handshake, mode selects, baud-generator strobes and the
//          serial/parallel data of one SPI shift-register stage.
// Signals:
//   ss, send_data                 slave select (active low) and one-cycle start pulse
//   lsbfe, cpol, cpha             bit order and clock mode selects
//   flag_low/high, flags_low/high sclk edge anticipation strobes from the baud generator
//   data_mosi, miso               parallel transmit word, serial input
//   mosi, data_miso               serial output, last completed received word
//   receive_data, busy            completion pulse, frame in progress
// Modports: master = control side (drives requests), slave = shift register.
interface spi_shift_register_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  ss;
  logic                  send_data;
  logic                  lsbfe;
  logic                  cpol;
  logic                  cpha;
  logic                  flag_low;
  logic                  flag_high;
  logic                  flags_low;
  logic                  flags_high;
  logic [DATA_WIDTH-1:0] data_mosi;
  logic                  miso;
  logic                  mosi;
  logic [DATA_WIDTH-1:0] data_miso;
  logic                  receive_data;
  logic                  busy;

  modport master (
    output ss, send_data, lsbfe, cpol, cpha,
    output flag_low, flag_high, flags_low, flags_high,
    output data_mosi, miso,
    input  mosi, data_miso, receive_data, busy
  );

  modport slave (
    input  ss, send_data, lsbfe, cpol, cpha,
    input  flag_low, flag_high, flags_low, flags_high,
    input  data_mosi, miso,
    output mosi, data_miso, receive_data, busy
  );
endinterface

// File: rtl/spi_shift_register.sv
// rtl/spi_shift_register.sv - SPI serialiser/deserialiser driven by baud generator edge flags
//
// Purpose: shifts a parallel word out on mosi and collects miso into a parallel word,
//          honouring CPOL/CPHA and LSB/MSB-first order, one frame per send_data pulse.
// Ports:
//   PCLK    system clock, rising edge
//   PRESET  asynchronous active-high reset
//   bus     spi_shift_register_if.slave (see interface header for signal list)
module spi_shift_register #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_W      = $clog2(DATA_WIDTH + 1)
) (
  input logic                 PCLK,
  input logic                 PRESET,
  spi_shift_register_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d;
  logic [DATA_WIDTH-1:0] rx_sr_q, rx_sr_d;
  logic [DATA_WIDTH-1:0] data_miso_q, data_miso_d;
  logic [CNT_W-1:0]      tx_cnt_q, tx_cnt_d;
  logic [CNT_W-1:0]      rx_cnt_q, rx_cnt_d;
  logic                  lsb_q, lsb_d;
  logic                  mosi_q, mosi_d;

  // Modes 1 and 2 sample on sclk high-to-low and drive ahead of the rising edge;
  // modes 0 and 3 are the mirror image.
  logic                  mode_odd;
  logic                  sample_stb;
  logic                  drive_stb;
  logic [DATA_WIDTH-1:0] tx_rshift;
  logic [DATA_WIDTH-1:0] tx_lshift;
  logic                  tx_next_bit;
  logic                  load_first_bit;
  logic [DATA_WIDTH-1:0] rx_shifted;

  assign mode_odd   = bus.cpol ^ bus.cpha;
  assign sample_stb = mode_odd ? bus.flag_high : bus.flag_low;
  assign drive_stb  = mode_odd ? bus.flags_low : bus.flags_high;

  // Bit tx_cnt in the latched order, picked by shifting so the index width never matters.
  assign tx_rshift   = tx_sr_q >> tx_cnt_q;
  assign tx_lshift   = tx_sr_q << tx_cnt_q;
  assign tx_next_bit = lsb_q ? tx_rshift[0] : tx_lshift[DATA_WIDTH-1];

  // At LOAD the word is not yet in tx_sr, so the first bit comes straight from the bus.
  assign load_first_bit = bus.lsbfe ? bus.data_mosi[0] : bus.data_mosi[DATA_WIDTH-1];

  // LSB-first enters at the top and moves right; MSB-first enters at bit 0 and moves left.
  assign rx_shifted = lsb_q ? {bus.miso, rx_sr_q[DATA_WIDTH-1:1]}
                            : {rx_sr_q[DATA_WIDTH-2:0], bus.miso};

  always_comb begin
    state_d     = state_q;
    tx_sr_d     = tx_sr_q;
    rx_sr_d     = rx_sr_q;
    data_miso_d = data_miso_q;
    tx_cnt_d    = tx_cnt_q;
    rx_cnt_d    = rx_cnt_q;
    lsb_d       = lsb_q;
    mosi_d      = mosi_q;

    case (state_q)
      IDLE: begin
        if (bus.send_data && !bus.ss) begin
          state_d = LOAD;
        end
      end

      LOAD: begin
        if (bus.ss) begin
          state_d  = IDLE;
          mosi_d   = 1'b0;
          tx_cnt_d = '0;
          rx_cnt_d = '0;
        end else begin
          tx_sr_d  = bus.data_mosi;
          lsb_d    = bus.lsbfe;
          rx_sr_d  = '0;
          tx_cnt_d = '0;
          rx_cnt_d = '0;
          // With cpha=0 the first bit must already be valid before the first sampling edge.
          if (!bus.cpha) begin
            mosi_d   = load_first_bit;
            tx_cnt_d = CNT_ONE;
          end
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        if (bus.ss) begin
          state_d  = IDLE;
          mosi_d   = 1'b0;
          tx_cnt_d = '0;
          rx_cnt_d = '0;
        end else begin
          if (drive_stb && (tx_cnt_q < CNT_FULL)) begin
            mosi_d   = tx_next_bit;
            tx_cnt_d = tx_cnt_q + CNT_ONE;
          end
          if (sample_stb && (rx_cnt_q < CNT_FULL)) begin
            rx_sr_d  = rx_shifted;
            rx_cnt_d = rx_cnt_q + CNT_ONE;
          end
          // Publish the word on the same edge that leaves SHIFT so data_miso is already
          // valid while receive_data is high in DONE.
          if (rx_cnt_d == CNT_FULL) begin
            data_miso_d = rx_sr_d;
            state_d     = DONE;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q     <= IDLE;
      tx_sr_q     <= '0;
      rx_sr_q     <= '0;
      data_miso_q <= '0;
      tx_cnt_q    <= '0;
      rx_cnt_q    <= '0;
      lsb_q       <= 1'b0;
      mosi_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tx_sr_q     <= tx_sr_d;
      rx_sr_q     <= rx_sr_d;
      data_miso_q <= data_miso_d;
      tx_cnt_q    <= tx_cnt_d;
      rx_cnt_q    <= rx_cnt_d;
      lsb_q       <= lsb_d;
      mosi_q      <= mosi_d;
    end
  end

  assign bus.mosi         = mosi_q;
  assign bus.data_miso    = data_miso_q;
  assign bus.receive_data = (state_q == DONE);
  assign bus.busy         = (state_q == LOAD) || (state_q == SHIFT);

endmodule

// File: tb/tb_spi_shift_register.sv
// tb/tb_spi_shift_register.sv - self-checking bench for spi_shift_register
module tb_spi_shift_register;
  localparam int W = 8;

  logic PCLK = 1'b0;
  logic PRESET;

  spi_shift_register_if #(.DATA_WIDTH(W)) bus ();

  spi_shift_register #(.DATA_WIDTH(W)) dut (
    .PCLK  (PCLK),
    .PRESET(PRESET),
    .bus   (bus)
  );

  always #5 PCLK = ~PCLK;

  int   total = 0;
  int   bad   = 0;
  logic prev_mosi;

  typedef struct {
    logic         cpol;
    logic         cpha;
    logic         lsb;
    logic [W-1:0] tx;
    logic [W-1:0] rx;
    bit           loopback;
    int           h;
    int           abort_at;
    int           midsend_at;
    int           reset_at;
    logic [W-1:0] exp_miso;
    int           exp_recv;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // k-th bit on the wire for word w in the chosen order.
  function automatic logic bit_at(input logic [W-1:0] w, input logic lsb, input int k);
    logic [W-1:0] r;
    logic [W-1:0] l;
    r = w >> k;
    l = w << k;
    return lsb ? r[0] : l[W-1];
  endfunction

  task automatic clear_flags();
    bus.flag_low   = 1'b0;
    bus.flag_high  = 1'b0;
    bus.flags_low  = 1'b0;
    bus.flags_high = 1'b0;
  endtask

  // One frame with an ideal baud generator of half-period h, started in the sclk idle half.
  task automatic run_frame(input vec_t v, input string tag);
    int   k;
    int   p;
    int   recv_cnt;
    int   recv_iter;
    int   last_iter;
    int   abort_iter;
    logic half;
    logic mode_odd;
    logic sample_now;
    bit   aborted;
    bit   ms_done;
    bit   busy_err;
    bit   was_reset;

    @(negedge PCLK);
    bus.cpol      = v.cpol;
    bus.cpha      = v.cpha;
    bus.lsbfe     = v.lsb;
    bus.data_mosi = v.tx;
    bus.ss        = 1'b0;
    bus.send_data = 1'b1;
    clear_flags();
    @(negedge PCLK);
    bus.send_data = 1'b0;
    check({tag, "_busy_load"}, bus.busy, 1);

    mode_odd   = v.cpol ^ v.cpha;
    k          = 0;
    p          = 0;
    half       = v.cpol;
    recv_cnt   = 0;
    recv_iter  = -1;
    last_iter  = -1;
    abort_iter = -1;
    aborted    = 0;
    ms_done    = 0;
    busy_err   = 0;
    was_reset  = 0;

    for (int iter = 0; iter < 4 * v.h * W + 16; iter++) begin
      @(negedge PCLK);
      bus.send_data = 1'b0;
      if (iter == 0) begin
        if (!v.cpha) check({tag, "_first_bit_at_load"}, bus.mosi, bit_at(v.tx, v.lsb, 0));
        else         check({tag, "_mosi_held_before_drive"}, bus.mosi, prev_mosi);
      end
      if (bus.receive_data) begin
        recv_cnt++;
        if (recv_iter < 0) recv_iter = iter;
      end
      if (k < W && !aborted && !bus.busy) busy_err = 1;
      if (recv_iter >= 0 && iter >= recv_iter + 2) break;

      if (v.reset_at >= 0 && k == v.reset_at) begin
        #2;
        PRESET = 1'b1;
        #1;
        check({tag, "_rst_busy"}, bus.busy, 0);
        check({tag, "_rst_mosi"}, bus.mosi, 0);
        check({tag, "_rst_data_miso"}, bus.data_miso, 0);
        check({tag, "_rst_receive"}, bus.receive_data, 0);
        @(negedge PCLK);
        PRESET = 1'b0;
        was_reset = 1;
        break;
      end

      if (aborted) begin
        if (iter == abort_iter + 1) begin
          check({tag, "_abort_busy"}, bus.busy, 0);
          check({tag, "_abort_mosi"}, bus.mosi, 0);
        end
        if (iter >= abort_iter + 6) break;
      end else if (v.abort_at >= 0 && k == v.abort_at) begin
        bus.ss     = 1'b1;
        aborted    = 1;
        abort_iter = iter;
      end

      if (v.midsend_at >= 0 && k == v.midsend_at && !ms_done) begin
        bus.send_data = 1'b1;
        bus.data_mosi = '0;
        bus.lsbfe     = ~v.lsb;
        ms_done       = 1;
      end

      clear_flags();
      if (p == v.h - 2) begin
        if (half) bus.flags_high = 1'b1;
        else      bus.flags_low  = 1'b1;
      end
      if (p == v.h - 1) begin
        if (half) bus.flag_high = 1'b1;
        else      bus.flag_low  = 1'b1;
      end
      sample_now = (p == v.h - 1) && (half == mode_odd);
      if (sample_now && k < W && !aborted) begin
        check($sformatf("%s_mosi_bit%0d", tag, k), bus.mosi, bit_at(v.tx, v.lsb, k));
        bus.miso = v.loopback ? bus.mosi : bit_at(v.rx, v.lsb, k);
        k++;
        if (k == W) last_iter = iter;
      end
      p++;
      if (p == v.h) begin
        p    = 0;
        half = ~half;
      end
    end

    clear_flags();
    bus.ss        = 1'b0;
    bus.send_data = 1'b0;

    if (was_reset) begin
      prev_mosi = 1'b0;
    end else begin
      check({tag, "_recv_count"}, recv_cnt, v.exp_recv);
      check({tag, "_busy_during_frame"}, busy_err, 0);
      check({tag, "_data_miso"}, bus.data_miso, v.exp_miso);
      if (v.exp_recv > 0) begin
        check({tag, "_recv_latency"}, recv_iter - last_iter, 1);
        prev_mosi = bit_at(v.tx, v.lsb, W - 1);
      end else begin
        prev_mosi = 1'b0;
      end
    end
  endtask

  initial begin
    vec_t rv;

    PRESET        = 1'b1;
    bus.ss        = 1'b1;
    bus.send_data = 1'b0;
    bus.lsbfe     = 1'b0;
    bus.cpol      = 1'b0;
    bus.cpha      = 1'b0;
    bus.data_mosi = '0;
    bus.miso      = 1'b0;
    clear_flags();
    prev_mosi = 1'b0;

    //          cpol cpha lsb  tx     rx     loop h  abort mid rst  exp    recv
    tbl[0] = '{1'b0, 1'b0, 1'b0, 8'hA5, 8'h3C, 0, 2, -1, -1, -1, 8'h3C, 1};
    tbl[1] = '{1'b0, 1'b0, 1'b0, 8'hFF, 8'h00, 0, 2,  4, -1, -1, 8'h3C, 0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 8'h81, 8'h5A, 0, 3, -1, -1, -1, 8'h5A, 1};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 8'hF0, 8'h00, 1, 2, -1, -1, -1, 8'hF0, 1};
    tbl[4] = '{1'b1, 1'b1, 1'b1, 8'hF0, 8'h00, 1, 4, -1, -1, -1, 8'hF0, 1};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 8'hC3, 8'h96, 0, 2, -1,  3, -1, 8'h96, 1};
    tbl[6] = '{1'b0, 1'b1, 1'b0, 8'hAA, 8'h11, 0, 3, -1, -1,  3, 8'h00, 0};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 8'h55, 8'h69, 0, 2, -1, -1, -1, 8'h69, 1};

    repeat (2) @(negedge PCLK);
    check("reset_mosi", bus.mosi, 0);
    check("reset_data_miso", bus.data_miso, 0);
    check("reset_receive", bus.receive_data, 0);
    check("reset_busy", bus.busy, 0);
    PRESET = 1'b0;

    // send_data while deselected must not start a frame.
    @(negedge PCLK);
    bus.ss        = 1'b1;
    bus.send_data = 1'b1;
    @(negedge PCLK);
    bus.send_data = 1'b0;
    check("ss_high_ignores_send", bus.busy, 0);
    @(negedge PCLK);
    check("ss_high_no_busy_later", bus.busy, 0);
    bus.ss = 1'b0;

    for (int i = 0; i < 8; i++) begin
      run_frame(tbl[i], $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 20; i++) begin
      rv.cpol       = 1'($urandom_range(0, 1));
      rv.cpha       = 1'($urandom_range(0, 1));
      rv.lsb        = 1'($urandom_range(0, 1));
      rv.tx         = W'($urandom);
      rv.rx         = W'($urandom);
      rv.loopback   = 0;
      rv.h          = int'($urandom_range(2, 5));
      rv.abort_at   = -1;
      rv.midsend_at = -1;
      rv.reset_at   = -1;
      rv.exp_miso   = rv.rx;
      rv.exp_recv   = 1;
      run_frame(rv, $sformatf("rnd%0d", i));
    end

    repeat (2) @(negedge PCLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_shift_register.md
Name: spi_shift_register

Overview:
- Serial data path stage directly downstream of baudrate_generator in the SPI core.
- Consumes the generator's edge-anticipation flags; serialises a parallel transmit word onto mosi and deserialises miso into a parallel receive word.
- Honours CPOL/CPHA and LSB-first selection, and signals completion of each frame to the APB/control logic.

Parameters:
- DATA_WIDTH, 8, frame length in bits; legal range 4..16.
- CNT_W, $clog2(DATA_WIDTH+1), bit-counter width.

Ports:
- PCLK  in  1  system clock; all logic on rising edge.
- PRESET  in  1  asynchronous active-high reset.
- ss  in  1  slave select, active low; high aborts any frame.
- send_data  in  1  one-cycle start pulse; loads data_mosi.
- lsbfe  in  1  1 = LSB first, 0 = MSB first; sampled at load.
- cpol  in  1  clock polarity.
- cpha  in  1  clock phase.
- flag_low  in  1  1-cycle pulse: sclk low, rises next PCLK.
- flag_high  in  1  1-cycle pulse: sclk high, falls next PCLK.
- flags_low  in  1  early pulse, one PCLK before flag_low.
- flags_high  in  1  early pulse, one PCLK before flag_high.
- data_mosi  in  DATA_WIDTH  parallel transmit word.
- miso  in  1  serial input.
- mosi  out  1  serial output.
- data_miso  out  DATA_WIDTH  last completed received word.
- receive_data  out  1  1-cycle pulse: data_miso updated.
- busy  out  1  frame in progress.

Behaviour:
- Reset (asynchronous, PRESET=1): mosi=0, data_miso=0, receive_data=0, busy=0, state=IDLE, shift registers=0, counters=0.
- Strobe selection, with m = cpol^cpha:
  - sample_stb = m ? flag_high : flag_low
  - drive_stb = m ? flags_low : flags_high
- FSM states: IDLE, LOAD, SHIFT, DONE.
- IDLE:
  - busy=0; mosi holds last value.
  - send_data=1 with ss=0 -> LOAD.
  - send_data with ss=1 is ignored.
- LOAD (1 cycle):
  - tx_sr<=data_mosi; lsb_r<=lsbfe; tx_cnt=rx_cnt=0; busy=1.
  - If cpha=0: mosi<=first bit (bit0 if lsb_r, else bit DATA_WIDTH-1) and tx_cnt<=1.
  - Go to SHIFT.
- SHIFT:
  - On drive_stb with tx_cnt<DATA_WIDTH: mosi<=tx bit[tx_cnt] in the selected order; tx_cnt++.
  - On sample_stb: miso shifted into rx_sr in the selected order (LSB-first fills from MSB end, shifting right; MSB-first shifts left, inserting at bit0); rx_cnt++.
  - drive_stb and sample_stb in the same cycle: both actions occur.
  - When rx_cnt reaches DATA_WIDTH, the final sample is included -> DONE.
- DONE (1 cycle):
  - data_miso<=rx_sr (including the last sampled bit); receive_data=1; busy=0.
  - -> IDLE.
  - Latency from last sample_stb to receive_data: 1 PCLK.
- send_data while busy: ignored; the frame in progress is not disturbed.
- ss=1 in LOAD/SHIFT: abort.
  - Next cycle state=IDLE, busy=0, mosi=0, no receive_data, data_miso unchanged.
- ss=1 in DONE: completion still reported.
- Counters saturate at DATA_WIDTH; extra strobes after the count is reached are ignored.
- No bits are dropped or duplicated at any sclk divisor, including the minimum divisor (2 PCLK per sclk half-period).
- data_mosi and lsbfe changes after LOAD have no effect on the current frame.
- PRESET asserted mid-frame: immediate return to reset values.

Test Plan:
- Mode 0 (cpol=0,cpha=0), lsbfe=0, data_mosi=8'hA5, miso driven with 8'h3C MSB-first on generator edges -> mosi sequence 1,0,1,0,0,1,0,1 (first bit valid at LOAD); receive_data pulses once 1 PCLK after 8th sample; data_miso=8'h3C.
- Mode 1 (cpol=0,cpha=1), lsbfe=1, data_mosi=8'h81, miso=8'h5A LSB-first -> mosi 1,0,0,0,0,0,0,1, first bit changes on first drive_stb, not at LOAD; data_miso=8'h5A.
- Modes 2 and 3 with data_mosi=8'hF0 loopback (miso=mosi) -> data_miso=8'hF0 in each mode; sample_stb tracks flag_high/flag_low per m.
- ss raised after 4 samples of frame 8'hFF -> busy=0 next cycle, mosi=0, no receive_data, data_miso retains previous 8'h3C; next send_data starts a clean frame.
- send_data pulsed mid-frame with data_mosi=8'h00 while sending 8'hC3 -> 8'hC3 transmitted intact, exactly one receive_data.
- PRESET asserted asynchronously mid-SHIFT (between PCLK edges) -> outputs zero immediately; after release, send_data with 8'h55 completes normally.
